serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Parametrised multi-bit subtractor computing dif = a - b - bin over several clocks, BPC bits per cycle.
- Each cycle is a chain of BPC full-subtract cells, with the borrow carried in a register between cycles.
- Start/busy/done handshake. Result is held stable until the next operation completes.
- Serves as the area-lean arithmetic unit for multi-bit datapaths built on the 1-bit subtractor cells.

Parameters:
- WIDTH, 8: operand and result width in bits; must be ≥ 2.
- BPC, 1: bits processed per clock. Must divide WIDTH. N = WIDTH/BPC cycles per operation.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request a new operation; sampled only when idle or done.
- a, input, WIDTH: minuend, unsigned or two's complement.
- b, input, WIDTH: subtrahend.
- bin, input, 1: borrow-in.
- busy, output, 1: high while an operation is in progress.
- done, output, 1: one-cycle pulse when results update.
- dif, output, WIDTH: difference a - b - bin, modulo 2^WIDTH.
- bout, output, 1: borrow out of the MSB; 1 when a < b + bin, unsigned.
- ovf, output, 1: signed overflow = borrow into MSB XOR bout.
- zero, output, 1: 1 when dif == 0.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - busy, done, dif, bout, ovf and zero = 0.
  - Internal shift registers, counter and borrow register = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - Capture a and b into shift registers and bin into the borrow register.
  - Clear the cycle counter; go to RUN; busy=1 from E0.
- RUN, each edge:
  - The BPC LSBs of the operand registers pass through BPC chained full-subtract cells, seeded by the borrow register.
  - The BPC difference bits shift into the result register from the top; operands shift right by BPC.
  - The borrow register takes the chain's final borrow; counter increments.
- At the Nth RUN edge (EN):
  - Write dif, bout, zero and ovf from the completed result. For ovf, latch the borrow into the MSB from inside the final chain.
  - Set done=1 and busy=0; go to DONE.
- DONE: lasts exactly one cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back operations, busy=1 again, done drops).
  - Otherwise go to IDLE.
- Latency: done is seen N cycles after the start cycle. Throughput is one operation per N+1 cycles.
- start during RUN is ignored: no restart, no operand capture, no queuing.
- Output hold:
  - dif, bout, ovf and zero change only at a completion edge.
  - Between completions they hold the last result, or reset values if none yet.
  - Operand inputs may change freely after the start cycle.
- Reset mid-operation:
  - Abort immediately; all outputs return to reset values next cycle.
  - No done pulse for the aborted operation.
- Arithmetic:
  - Exact WIDTH-bit two's-complement subtraction with no saturation.
  - bout is the inverted carry of a + ~b + ~bin.
- BPC = WIDTH is legal: N = 1, single RUN cycle.

Test Plan (WIDTH=8, BPC=1 unless noted):
- a=0x5A, b=0x3C, bin=0, start pulse → busy for 8 cycles, then done 1 cycle; dif=0x1E, bout=0, ovf=0, zero=0.
- a=0x00, b=0x01, bin=0 → dif=0xFF, bout=1, ovf=0. Then a=0x80, b=0x01 → dif=0x7F, bout=0, ovf=1.
- a=0x10, b=0x0F, bin=1 → dif=0x00, zero=1, bout=0.
- Start 0x5A-0x3C. Pulse start with a=0xFF, b=0x00 at RUN cycle 3, and change a/b every cycle → result still 0x1E; done still at cycle 8; no second operation starts.
- Hold start high continuously with a=0x20, b=0x01 → done every 9 cycles, dif=0x1F each time; outputs unchanged between done pulses.
- Assert rst at RUN cycle 4 → next cycle busy=0, dif=0, no done. Then WIDTH=8, BPC=4: a=0x5A, b=0x3C → done after 2 cycles, dif=0x1E.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Multi-cycle subtractor: dif = a - b - bin (mod 2^WIDTH), computed BPC bits
//   per clock through a chain of full-subtract cells. The borrow between
//   consecutive slices is held in a register, so one operation takes
//   N = WIDTH/BPC RUN cycles.
//
// Ports
//   clk_i    rising-edge clock
//   rst_i    synchronous, active-high reset
//   start_i  request a new operation (accepted in IDLE or DONE)
//   a_i      minuend  [WIDTH-1:0]
//   b_i      subtrahend [WIDTH-1:0]
//   bin_i    borrow-in
//   busy_o   operation in progress
//   done_o   one-cycle pulse when the result outputs update
//   dif_o    difference [WIDTH-1:0]
//   bout_o   borrow out of the MSB (unsigned a < b + bin)
//   ovf_o    signed overflow (borrow into MSB xor borrow out)
//   zero_o   dif_o == 0
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start_i; outputs hold the last result
// RUN   | one BPC-bit slice subtracted per clock, N clocks in total
// DONE  | single cycle after completion; start_i here begins a new op
//
// WIDTH must be >= 2 and BPC must divide WIDTH.

module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] dif_o,
    output logic             bout_o,
    output logic             ovf_o,
    output logic             zero_o
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             brw_q;
    logic [CW-1:0]    cnt_q;

    logic [BPC-1:0]   cell_d;
    logic [BPC:0]     cell_br;
    logic [WIDTH-1:0] res_d;
    logic             last_run;

    // Chain of BPC full-subtract cells on the low slice of the operand
    // shift registers. cell_br[i] is the borrow into bit i of the slice,
    // so cell_br[BPC-1] on the final slice is the borrow into the MSB.
    always_comb begin
        cell_d     = '0;
        cell_br    = '0;
        cell_br[0] = brw_q;
        for (int i = 0; i < BPC; i++) begin
            cell_d[i]    = a_q[i] ^ b_q[i] ^ cell_br[i];
            cell_br[i+1] = (~a_q[i] & b_q[i]) |
                           (~(a_q[i] ^ b_q[i]) & cell_br[i]);
        end
    end

    // New difference bits enter the result register from the top; after N
    // slices the first slice has reached the bottom.
    assign res_d    = (res_q >> BPC) | (WIDTH'(cell_d) << (WIDTH - BPC));
    assign last_run = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            dif_o   <= '0;
            bout_o  <= 1'b0;
            ovf_o   <= 1'b0;
            zero_o  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        brw_q   <= bin_i;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_o  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_o  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                RUN: begin
                    // start_i is deliberately not looked at here.
                    a_q   <= a_q >> BPC;
                    b_q   <= b_q >> BPC;
                    res_q <= res_d;
                    brw_q <= cell_br[BPC];
                    cnt_q <= cnt_q + 1'b1;
                    if (last_run) begin
                        dif_o   <= res_d;
                        bout_o  <= cell_br[BPC];
                        ovf_o   <= cell_br[BPC-1] ^ cell_br[BPC];
                        zero_o  <= (res_d == '0);
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                        state_q <= DONE;
                    end
                end

                default: begin
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       s1, s4;
    logic [7:0] a1, b1, a4, b4;
    logic       bi1, bi4;
    logic       busy1, done1, bout1, ovf1, zero1;
    logic       busy4, done4, bout4, ovf4, zero4;
    logic [7:0] dif1, dif4;

    int total = 0;
    int bad   = 0;
    bit sel   = 1'b0;   // 0: BPC=1 instance, 1: BPC=4 instance

    serial_subtractor #(.WIDTH(8), .BPC(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(s1), .a_i(a1), .b_i(b1), .bin_i(bi1),
        .busy_o(busy1), .done_o(done1), .dif_o(dif1), .bout_o(bout1),
        .ovf_o(ovf1), .zero_o(zero1)
    );

    serial_subtractor #(.WIDTH(8), .BPC(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(s4), .a_i(a4), .b_i(b4), .bin_i(bi4),
        .busy_o(busy4), .done_o(done4), .dif_o(dif4), .bout_o(bout4),
        .ovf_o(ovf4), .zero_o(zero4)
    );

    wire       o_busy = sel ? busy4 : busy1;
    wire       o_done = sel ? done4 : done1;
    wire [7:0] o_dif  = sel ? dif4  : dif1;
    wire       o_bout = sel ? bout4 : bout1;
    wire       o_ovf  = sel ? ovf4  : ovf1;
    wire       o_zero = sel ? zero4 : zero1;
    wire [10:0] o_res = {o_dif, o_bout, o_ovf, o_zero};

    // Reference: plain integer arithmetic on the whole operands.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output logic [10:0] exp_res);
        int ur, sr;
        logic [7:0] d;
        ur = int'(a) - int'(b) - int'(bin);
        sr = int'($signed(a)) - int'($signed(b)) - int'(bin);
        d  = 8'(ur & 255);
        exp_res = {d, (ur < 0), (sr < -128 || sr > 127), (d == 8'h00)};
    endtask

    task automatic drive(input logic st, input logic [7:0] a, input logic [7:0] b,
                         input logic bin);
        if (sel) begin s4 = st; a4 = a; b4 = b; bi4 = bin; end
        else     begin s1 = st; a1 = a; b1 = b; bi1 = bin; end
    endtask

    // Runs one operation; lat counts falling edges from the start edge until
    // done is seen. busy_gaps / early count RUN cycles with busy low or with
    // result outputs changed before completion.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input bit hammer, output int lat, output int busy_gaps,
                          output int early);
        logic [10:0] snap;
        int n;
        n = sel ? 2 : 8;
        snap = o_res;
        busy_gaps = 0;
        early = 0;
        @(negedge clk);
        drive(1'b1, a, b, bin);
        @(negedge clk);
        if (hammer) drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        else        drive(1'b0, a, b, bin);
        lat = 1;
        while (!o_done && lat < n + 6) begin
            if (!o_busy) busy_gaps++;
            if (o_res !== snap) early++;
            if (hammer)
                drive(lat == 3, (lat == 3) ? 8'hFF : 8'($urandom),
                      (lat == 3) ? 8'h00 : 8'($urandom), 1'($urandom));
            @(negedge clk);
            lat++;
        end
        drive(1'b0, a, b, bin);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({busy1, done1, dif1, bout1, ovf1, zero1} !== 13'b0) begin
            bad++;
            $display("FAIL reset_bpc1: got %b want 0", {busy1, done1, dif1, bout1, ovf1, zero1});
        end
        total++;
        if ({busy4, done4, dif4, bout4, ovf4, zero4} !== 13'b0) begin
            bad++;
            $display("FAIL reset_bpc4: got %b want 0", {busy4, done4, dif4, bout4, ovf4, zero4});
        end
    endtask

    task automatic test_directed;
        logic [7:0]  va [4] = '{8'h5A, 8'h00, 8'h80, 8'h10};
        logic [7:0]  vb [4] = '{8'h3C, 8'h01, 8'h01, 8'h0F};
        logic        vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [10:0] ve [4] = '{{8'h1E, 3'b000}, {8'hFF, 3'b100},
                                {8'h7F, 3'b010}, {8'h00, 3'b001}};
        int lat, gaps, early;
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vc[i], 1'b0, lat, gaps, early);
            total++;
            if (lat !== 9) begin
                bad++; $display("FAIL dir_latency[%0d]: got %0d want 9", i, lat);
            end
            total++;
            if (gaps !== 0 || early !== 0) begin
                bad++; $display("FAIL dir_busy_hold[%0d]: gaps=%0d early=%0d want 0/0", i, gaps, early);
            end
            total++;
            if (o_res !== ve[i]) begin
                bad++; $display("FAIL dir_result[%0d]: got %h want %h", i, o_res, ve[i]);
            end
            @(negedge clk);
            total++;
            if (o_done !== 1'b0 || o_busy !== 1'b0 || o_res !== ve[i]) begin
                bad++;
                $display("FAIL dir_after_done[%0d]: done=%b busy=%b res=%h want 0 0 %h",
                         i, o_done, o_busy, o_res, ve[i]);
            end
        end
    endtask

    task automatic test_random(input bit which, input int count);
        logic [7:0]  a, b;
        logic        bin;
        logic [10:0] exp_res;
        int lat, gaps, early, want_lat;
        sel = which;
        want_lat = which ? 3 : 9;
        for (int i = 0; i < count; i++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            if (i == 0) begin a = 8'h5A; b = 8'h3C; bin = 1'b0; end
            model(a, b, bin, exp_res);
            run_op(a, b, bin, 1'b0, lat, gaps, early);
            total++;
            if (lat !== want_lat || gaps !== 0) begin
                bad++;
                $display("FAIL rand_timing sel=%0d op=%0d: lat=%0d gaps=%0d want %0d/0",
                         which, i, lat, gaps, want_lat);
            end
            total++;
            if (o_res !== exp_res) begin
                bad++;
                $display("FAIL rand_result sel=%0d %h-%h-%b: got %h want %h",
                         which, a, b, bin, o_res, exp_res);
            end
        end
    endtask

    task automatic test_start_ignored;
        int lat, gaps, early;
        sel = 1'b0;
        run_op(8'h5A, 8'h3C, 1'b0, 1'b1, lat, gaps, early);
        total++;
        if (lat !== 9 || gaps !== 0) begin
            bad++; $display("FAIL ignore_timing: lat=%0d gaps=%0d want 9/0", lat, gaps);
        end
        total++;
        if (o_res !== {8'h1E, 3'b000}) begin
            bad++; $display("FAIL ignore_result: got %h want %h", o_res, {8'h1E, 3'b000});
        end
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            bad++; $display("FAIL ignore_no_restart: busy=%b done=%b want 0 0", o_busy, o_done);
        end
    endtask

    task automatic test_back_to_back;
        int last_done, pulses, bad_int, bad_val, bad_busy;
        sel = 1'b0;
        last_done = 0; pulses = 0; bad_int = 0; bad_val = 0; bad_busy = 0;
        @(negedge clk);
        drive(1'b1, 8'h20, 8'h01, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (o_done) begin
                if (k - last_done != 9) bad_int++;
                if (o_res !== {8'h1F, 3'b000}) bad_val++;
                last_done = k;
                pulses++;
            end else begin
                if (!o_busy) bad_busy++;
                if (pulses > 0 && o_res !== {8'h1F, 3'b000}) bad_val++;
            end
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        total++;
        if (pulses !== 4 || bad_int !== 0) begin
            bad++; $display("FAIL b2b_period: pulses=%0d bad_intervals=%0d want 4/0", pulses, bad_int);
        end
        total++;
        if (bad_val !== 0) begin
            bad++; $display("FAIL b2b_value: bad=%0d want 0", bad_val);
        end
        total++;
        if (bad_busy !== 0) begin
            bad++; $display("FAIL b2b_busy: low_cycles=%0d want 0", bad_busy);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int dones;
        sel = 1'b0;
        @(negedge clk);
        drive(1'b1, 8'h5A, 8'h3C, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h5A, 8'h3C, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({o_busy, o_done, o_res} !== 13'b0) begin
            bad++; $display("FAIL rst_mid_outputs: got %b want 0", {o_busy, o_done, o_res});
        end
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (o_done || o_busy) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++; $display("FAIL rst_mid_no_done: active_cycles=%0d want 0", dones);
        end
    endtask

    initial begin
        rst = 1'b1;
        s1 = 1'b0; a1 = '0; b1 = '0; bi1 = 1'b0;
        s4 = 1'b0; a4 = '0; b4 = '0; bi4 = 1'b0;
        test_reset();
        test_directed();
        test_random(1'b0, 24);
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random(1'b1, 16);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
